// File: rtl/buffer_pkg.sv
// ============================================================================
// buffer_pkg : shared types and width helpers for the circular register buffer
//              and its pointer/flow-control sequencer.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package buffer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } ctrl_state_t;

  function automatic int addr_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  function automatic int cnt_w(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/buffer_ctrl_if.sv
// ============================================================================
// buffer_ctrl_if : producer/consumer handshakes and buffer address bus of the
//                  buffer sequencer.
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface buffer_ctrl_if #(
  parameter int SIZE = 8
);
  logic                                  start;
  logic                                  in_valid;
  logic                                  in_last;
  logic                                  in_ready;
  logic                                  out_valid;
  logic                                  out_ready;
  logic [buffer_pkg::addr_w(SIZE)-1:0]   write_addr;
  logic                                  write_en;
  logic [buffer_pkg::addr_w(SIZE)-1:0]   read_addr;
  logic [buffer_pkg::cnt_w(SIZE)-1:0]    count;
  logic                                  done;

  modport master (
    output start, in_valid, in_last, out_ready,
    input  in_ready, out_valid, write_addr, write_en, read_addr, count, done
  );

  modport slave (
    input  start, in_valid, in_last, out_ready,
    output in_ready, out_valid, write_addr, write_en, read_addr, count, done
  );
endinterface

`default_nettype wire

// File: rtl/buffer_ctrl_ring_pointer.sv
// ============================================================================
// ring_pointer : wrap-by-overflow buffer pointer advancing STEP per increment,
//                with a synchronous clear.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module ring_pointer
  import buffer_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int STEP = 1
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    inc_i,
  input  wire logic                    clr_i,
  output logic [addr_w(SIZE)-1:0]      ptr_o
);
  localparam int            AW     = addr_w(SIZE);
  localparam logic [AW-1:0] STEP_C = AW'(STEP);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = ptr_q + STEP_C;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

`default_nettype wire

// File: rtl/buffer_ctrl.sv
// ============================================================================
// buffer_ctrl : pointer, occupancy and start/drain/done sequencer for the
//               multi-word circular register buffer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module buffer_ctrl
  import buffer_pkg::*;
#(
  parameter int SIZE        = 8,
  parameter int WRITE_SIZE  = 2,
  parameter int READ_SIZE   = 2,
  parameter int READ_STRIDE = 1
) (
  input  wire logic    clk,
  input  wire logic    rst,
  buffer_ctrl_if.slave bus
);
  localparam int CW  = cnt_w(SIZE);
  localparam int CW1 = CW + 1;
  localparam int AW  = addr_w(SIZE);

  localparam logic [CW-1:0] FULL_LIM_C = CW'(SIZE - WRITE_SIZE);
  localparam logic [CW-1:0] READ_C     = CW'(READ_SIZE);
  localparam logic [CW:0]   WR_INC_C   = CW1'(WRITE_SIZE);
  localparam logic [CW:0]   RD_DEC_C   = CW1'(READ_STRIDE);
  localparam logic [CW:0]   SIZE_C     = CW1'(SIZE);

  ctrl_state_t   state_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW:0]   count_sum;
  logic          done_q;
  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;
  logic          drain_exit;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  // Same-cycle pops are not credited, so readiness depends only on count_q.
  assign in_ready   = (state_q == RUN) && (count_q <= FULL_LIM_C);
  assign out_valid  = (state_q != IDLE) && (count_q >= READ_C);
  assign push       = bus.in_valid && in_ready;
  assign pop        = out_valid && bus.out_ready;
  assign drain_exit = (state_q == DRAIN) && (count_q < READ_C);

  always_comb begin
    count_sum = {1'b0, count_q};
    if (push) count_sum = count_sum + WR_INC_C;
    if (pop)  count_sum = count_sum - RD_DEC_C;
    // Handshake gating keeps the sum in [0, SIZE]; hold rather than wrap otherwise.
    count_d = (count_sum > SIZE_C) ? count_q : count_sum[CW-1:0];
  end

  ring_pointer #(.SIZE(SIZE), .STEP(WRITE_SIZE)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (push),
    .clr_i (drain_exit),
    .ptr_o (wr_ptr)
  );

  ring_pointer #(.SIZE(SIZE), .STEP(READ_STRIDE)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (pop),
    .clr_i (drain_exit),
    .ptr_o (rd_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      count_q <= count_d;
      case (state_q)
        // A start coinciding with the done pulse belongs to the finished frame.
        IDLE:    if (bus.start && !done_q) state_q <= RUN;
        RUN:     if (push && bus.in_last) state_q <= DRAIN;
        DRAIN: begin
          if (drain_exit) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.write_en   = push;
  assign bus.write_addr = wr_ptr;
  assign bus.read_addr  = rd_ptr;
  assign bus.count      = count_q;
  assign bus.done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_buffer_ctrl.sv
// ============================================================================
// tb_buffer_ctrl : directed self-checking bench for buffer_ctrl at default
//                  parameters (SIZE=8, WRITE_SIZE=2, READ_SIZE=2, STRIDE=1).
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_buffer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  buffer_ctrl_if #(.SIZE(8)) bus();

  buffer_ctrl #(
    .SIZE        (8),
    .WRITE_SIZE  (2),
    .READ_SIZE   (2),
    .READ_STRIDE (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mc;
    int mw;
    int pops;
    bit mpush;
    bit mpop;

    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_in_ready",  bus.in_ready,   0);
    chk("rst_out_valid", bus.out_valid,  0);
    chk("rst_write_en",  bus.write_en,   0);
    chk("rst_write_addr",bus.write_addr, 0);
    chk("rst_read_addr", bus.read_addr,  0);
    chk("rst_count",     bus.count,      0);
    chk("rst_done",      bus.done,       0);

    // first push, consumer stalled
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("run_in_ready",  bus.in_ready,  1);
    chk("run_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b1; #1;
    chk("push_we",    bus.write_en,   1);
    chk("push_waddr", bus.write_addr, 0);
    tick(); bus.in_valid = 1'b0;
    chk("p1_count",  bus.count,      2);
    chk("p1_ovalid", bus.out_valid,  1);
    chk("p1_raddr",  bus.read_addr,  0);
    chk("p1_waddr",  bus.write_addr, 2);

    // fill to full, then a refused fifth push
    bus.in_valid = 1'b1;
    repeat (3) tick();
    chk("full_count",    bus.count,      8);
    chk("full_in_ready", bus.in_ready,   0);
    chk("full_waddr",    bus.write_addr, 0);
    #1 chk("full_we",    bus.write_en,   0);
    tick();
    chk("full_count2",   bus.count,      8);
    chk("full_waddr2",   bus.write_addr, 0);
    bus.in_valid = 1'b0;

    // pop to 7, then push+pop at 7: push refused, pop proceeds
    bus.out_ready = 1'b1; tick();
    chk("c7_count",    bus.count,     7);
    chk("c7_raddr",    bus.read_addr, 1);
    chk("c7_in_ready", bus.in_ready,  0);
    bus.in_valid = 1'b1; #1;
    chk("c7_we", bus.write_en, 0);
    tick();
    chk("pp_count", bus.count,      6);
    chk("pp_raddr", bus.read_addr,  2);
    chk("pp_waddr", bus.write_addr, 0);
    bus.in_valid = 1'b0; tick();
    chk("c5_count", bus.count, 5);
    bus.out_ready = 1'b0;

    // asynchronous reset mid-RUN at count 5
    bus.in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_count",     bus.count,      0);
    chk("arst_in_ready",  bus.in_ready,   0);
    chk("arst_out_valid", bus.out_valid,  0);
    chk("arst_raddr",     bus.read_addr,  0);
    chk("arst_waddr",     bus.write_addr, 0);
    chk("arst_we",        bus.write_en,   0);
    chk("arst_done",      bus.done,       0);
    bus.in_valid = 1'b0;
    tick();
    chk("arst_done2", bus.done, 0);
    rst = 1'b0;

    // steady stream: push every other cycle, consumer always ready
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    mc = 0; mw = 0; pops = 0;
    for (int i = 0; i < 60 && pops < 20; i++) begin
      chk("st_count",  bus.count,       mc);
      chk("st_range",  bus.count <= 8,  1);
      chk("st_ovalid", bus.out_valid,   mc >= 2);
      chk("st_iready", bus.in_ready,    mc <= 6);
      bus.in_valid  = (i % 2 == 0);
      bus.out_ready = 1'b1;
      mpush = (i % 2 == 0) && (mc <= 6);
      mpop  = (mc >= 2);
      #1;
      chk("st_we",    bus.write_en,   mpush);
      chk("st_waddr", bus.write_addr, mw);
      if (mpop) begin
        chk("st_raddr", bus.read_addr, pops % 8);
        pops++;
      end
      mc = mc + (mpush ? 2 : 0) - (mpop ? 1 : 0);
      if (mpush) mw = (mw + 2) % 8;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // frame end: last push at count 3, drain to 1, done pulse
    rst = 1'b1; tick(); rst = 1'b0;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    bus.in_valid = 1'b1; tick(); tick(); bus.in_valid = 1'b0;
    bus.in_last = 1'b1; bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
    chk("nl_count",    bus.count,    3);
    chk("nl_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1; tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
    chk("dr_count",    bus.count,      5);
    chk("dr_in_ready", bus.in_ready,   0);
    chk("dr_ovalid",   bus.out_valid,  1);
    chk("dr_waddr",    bus.write_addr, 6);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    chk("dr1_count",  bus.count,     1);
    chk("dr1_raddr",  bus.read_addr, 5);
    chk("dr1_ovalid", bus.out_valid, 0);
    chk("dr1_done",   bus.done,      0);
    bus.start = 1'b1; tick();
    chk("done_pulse", bus.done,       1);
    chk("done_count", bus.count,      0);
    chk("done_raddr", bus.read_addr,  0);
    chk("done_waddr", bus.write_addr, 0);
    chk("done_iready",bus.in_ready,   0);
    chk("done_ovalid",bus.out_valid,  0);
    tick();
    chk("post_done",   bus.done,     0);
    chk("post_iready", bus.in_ready, 0);
    bus.start = 1'b0; bus.out_ready = 1'b0; tick();
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    chk("restart_iready", bus.in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/buffer_ctrl.md
# buffer_ctrl

Pointer and flow-control sequencer for the multi-word circular register buffer (`SIZE` entries, `WRITE_SIZE` words written per push, `READ_SIZE`-word read window). The block converts valid/ready handshakes on a producer and a consumer into the buffer's `write_addr`, `write_en` and `read_addr`. It tracks occupancy so the buffer never overflows or exposes stale words, and it sequences a start/drain/done frame lifecycle. The block sits directly beside the buffer in the datapath: the producer streams word groups in, and the consumer takes sliding windows out.

## Interface
Parameters:
- `SIZE`, 8: buffer entries; must be a power of two.
- `WRITE_SIZE`, 2: words written per accepted push.
- `READ_SIZE`, 2: words in the read window.
- `READ_STRIDE`, 1: words retired per accepted pop; 1 ≤ `READ_STRIDE` ≤ `READ_SIZE`.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begins a frame; honoured only in IDLE.
- `in_valid` input 1: producer has `WRITE_SIZE` words on the buffer input.
- `in_last` input 1: the current push is the final push of the frame.
- `in_ready` output 1: push accepted this cycle when high together with `in_valid`.
- `out_valid` output 1: the window at `read_addr` holds `READ_SIZE` valid words.
- `out_ready` input 1: consumer takes the window.
- `write_addr` output `$clog2(SIZE)`: buffer write pointer.
- `write_en` output 1: buffer write enable.
- `read_addr` output `$clog2(SIZE)`: buffer read pointer.
- `count` output `$clog2(SIZE+1)`: current occupancy in words.
- `done` output 1: one-cycle pulse at the end of a frame.

## Operation
State machine with three states:
- IDLE:
  - `in_ready`=0 and `out_valid`=0.
  - `start`=1 → RUN.
- RUN:
  - `in_ready` = (`SIZE` − `count` ≥ `WRITE_SIZE`).
  - A pop in the same cycle is not credited toward `in_ready`; this is the conservative rule.
  - A push accepted with `in_last`=1 → DRAIN.
- DRAIN:
  - `in_ready`=0.
  - Pops continue while `count` ≥ `READ_SIZE`.
  - When `count` < `READ_SIZE` and no pop is in progress: clear `wr_ptr`, `rd_ptr` and `count`, pulse `done`, → IDLE.
  - Leftover words fewer than `READ_SIZE` are discarded.

Push and pop rules:
- Push = `in_valid` & `in_ready`. `write_en` = push (combinational). `write_addr` = `wr_ptr`. On push, `wr_ptr` += `WRITE_SIZE` mod `SIZE`.
- `out_valid` = (state ≠ IDLE) & (`count` ≥ `READ_SIZE`).
- Pop = `out_valid` & `out_ready`. `read_addr` = `rd_ptr`. On pop, `rd_ptr` += `READ_STRIDE` mod `SIZE`.

Occupancy arithmetic:
- `count` next = `count` + (push ? `WRITE_SIZE` : 0) − (pop ? `READ_STRIDE` : 0), computed at `$clog2(SIZE+1)`+1 bits.
- The result never leaves [0, `SIZE`]. The bench asserts this.

Pointer wrap:
- Pointer wrap is natural binary overflow; this requires `SIZE` to be a power of two.
- The buffer resolves window indices past `SIZE`−1 modulo `SIZE`.

## Timing
- Reset values: `wr_ptr`=0, `rd_ptr`=0, `count`=0, state=IDLE, `done`=0. Consequently `in_ready`=0, `out_valid`=0, `write_en`=0, `write_addr`=0, `read_addr`=0.
- Reset mid-frame aborts immediately and asynchronously. There is no `done` pulse.
- Write-to-read latency is 1 cycle. If a push at edge N raises `count` to ≥ `READ_SIZE`, then `out_valid` is high in the cycle after edge N, and the data is visible in the buffer in that same cycle.
- `in_ready` and `out_valid` depend only on registered state. They have no combinational path from `in_valid` or `out_ready`.
- Simultaneous push and pop in one cycle: both pointers advance and `count` is updated by the net delta.
- Full condition: `count` > `SIZE` − `WRITE_SIZE` forces `in_ready`=0.
- Empty condition: `count` < `READ_SIZE` forces `out_valid`=0.
- `start` asserted outside IDLE is ignored.
- `in_last` is ignored when no push occurs in that cycle.
- `done` is registered. It is high for exactly one cycle, the first cycle in IDLE.

## Structure
- Shared package `buffer_pkg`:
  - typedef `ctrl_state_t` {IDLE, RUN, DRAIN}.
  - functions `addr_w(SIZE)` and `cnt_w(SIZE)`.
  - Used by both this block and the buffer.
- One sub-module: `ring_pointer`, parameters `SIZE` and `STEP`. It holds a `$clog2(SIZE)` register with an `inc` input and a synchronous `clr` input, and wrap by overflow. It is instantiated twice, with `STEP`=`WRITE_SIZE` and `STEP`=`READ_STRIDE`.
- The FSM and occupancy counter live in the top module.
- Target size: 150–250 lines total.

## Test plan
All scenarios use the default parameters (`SIZE`=8, `WRITE_SIZE`=2, `READ_SIZE`=2, `READ_STRIDE`=1).
- Reset then `start`, one push, `out_ready`=0 → `write_en` and `write_addr`=0 at the push edge. Next cycle `count`=2, `out_valid`=1, `read_addr`=0.
- Four pushes with `out_ready`=0 → `count`=8, `in_ready`=0. A fifth `in_valid` is not written: `write_en` stays 0 and `wr_ptr` stays 0 (wrapped).
- Full, then push and pop in the same cycle from `count`=7 → push is refused because 8−7 < 2. Pop proceeds; `count`=6 and `rd_ptr` advances by 1.
- Steady stream (push every other cycle, `out_ready`=1 always) over 20 pops → `read_addr` sequence 0,1,…,7,0,… with no `out_valid` when `count` < 2. The `count` invariant holds throughout.
- Push with `in_last` at `count`=3, consumer pops → pops until `count`=1. Then `done` pulses once, state returns to IDLE, pointers=0 and `count`=0. `start` in the same cycle as `done` is ignored.
- Assert `rst` mid-RUN with `count`=5 → all outputs return to their reset values asynchronously, with no `done` pulse.
